// File: rtl/cache_trace_sequencer.sv
// Trace-driven cache access sequencer: reader -> cache handshake with run statistics.
// Optional REQ timeout with sticky error flag when CTRL_TIMEOUT_EN is defined.
module cache_trace_sequencer #(
  parameter int ADDR_W  = 15,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  input  logic [ADDR_W-1:0] rd_data,
  input  logic              rd_finish,
  output logic              cache_req,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_ready,
  input  logic              cache_hit,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, REQ, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cache_addr = addr_q;

`ifdef CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              error_q;
  assign error = error_q;
`else
  wire unused_timeout = |TIMEOUT;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rd_en        <= 1'b0;
      cache_req    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      addr_q       <= '0;
      last_q       <= 1'b0;
      access_count <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
`ifdef CTRL_TIMEOUT_EN
      wait_cnt     <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
`ifdef CTRL_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
            rd_en        <= 1'b1;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          addr_q    <= rd_data;
          last_q    <= rd_finish;
          cache_req <= 1'b1;
`ifdef CTRL_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          state     <= REQ;
        end
        REQ: begin
          if (cache_ready) begin
            access_count <= sat_inc(access_count);
            if (cache_hit) hit_count <= sat_inc(hit_count);
            else           miss_count <= sat_inc(miss_count);
            cache_req <= 1'b0;
            if (last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_en <= 1'b1;
              state <= FETCH;
            end
          end
`ifdef CTRL_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // access abandoned: statistics stay untouched
            error_q   <= 1'b1;
            cache_req <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_trace_sequencer.sv
// Directed bench for cache_trace_sequencer with reader and cache models.
// Timeout checks are compiled in when CTRL_TIMEOUT_EN is defined.
module tb_cache_trace_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd_en;
  logic [14:0] rd_data;
  logic        rd_finish;
  logic        cache_req;
  logic [14:0] cache_addr;
  logic        cache_ready;
  logic        cache_hit;
  logic        busy;
  logic        done;
  logic [15:0] access_count;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic        error;

  cache_trace_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_finish    (rd_finish),
    .cache_req    (cache_req),
    .cache_addr   (cache_addr),
    .cache_ready  (cache_ready),
    .cache_hit    (cache_hit),
    .busy         (busy),
    .done         (done),
    .access_count (access_count),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .error        (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [14:0] trace [0:7];
  int          trace_len;
  logic [7:0]  hit_mask;
  int          delay;
  logic        stuck;

  // reader: data appears the cycle after En
  int idx;
  always @(posedge clk) begin
    if (!busy) begin
      idx <= 0;
    end else if (rd_en) begin
      rd_data   <= trace[idx & 7];
      rd_finish <= (idx == trace_len - 1);
      idx       <= idx + 1;
    end
  end

  logic [2:0] acc;
  int         wait_ctr;
  always @(posedge clk) begin
    if (!busy) acc <= '0;
    else if (cache_req && cache_ready) acc <= acc + 1'b1;
    if (!cache_req || cache_ready) wait_ctr <= 0;
    else wait_ctr <= wait_ctr + 1;
  end
  assign cache_ready = !stuck && (wait_ctr >= delay);
  assign cache_hit   = hit_mask[acc];

  int          cyc = 0;
  int          tot_rd = 0;
  int          tot_xfer = 0;
  int          tot_done = 0;
  int          unstable = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          xfer_cyc [0:63];
  logic [14:0] xfer_addr [0:63];
  logic        prev_busy = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ready = 1'b0;
  logic [14:0] prev_addr = '0;
  logic [15:0] prev_acc = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_en === 1'b1) tot_rd <= tot_rd + 1;
    if (cache_req === 1'b1 && cache_ready) begin
      xfer_cyc[tot_xfer & 63]  <= cyc;
      xfer_addr[tot_xfer & 63] <= cache_addr;
      tot_xfer <= tot_xfer + 1;
    end
    if (done === 1'b1) begin
      tot_done <= tot_done + 1;
      done_cyc <= cyc;
    end
    if (busy === 1'b1 && !prev_busy) start_cyc <= cyc;
    if (cache_req && prev_req && !prev_ready &&
        (cache_addr !== prev_addr || access_count !== prev_acc))
      unstable <= unstable + 1;
    prev_busy  <= busy;
    prev_req   <= cache_req;
    prev_ready <= cache_ready;
    prev_addr  <= cache_addr;
    prev_acc   <= access_count;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_t1();
    trace[0] = 15'h0010;
    trace[1] = 15'h0010;
    trace[2] = 15'h4010;
    trace[3] = 15'h0010;
    trace_len = 4;
    hit_mask = 8'b0000_0010;
  endtask

  // start one run; optional extra start pulse at loop step pulse_at
  task automatic run(input int pulse_at, input int budget);
    int d0;
    d0 = tot_done;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < budget && tot_done == d0; i++) begin
      start = (i == pulse_at);
      step();
    end
    start = 1'b0;
    chk("run_done_pulses", tot_done - d0, 1);
    step();
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  int b_rd, b_x, b_u, d0, r0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    delay = 0;
    stuck = 1'b0;
    trace_len = 1;
    hit_mask = '0;
    for (int i = 0; i < 8; i++) trace[i] = '0;
    step();
    step();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_cache_req", cache_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cache_addr", cache_addr, 0);
    chk("rst_access", access_count, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    rst = 1'b0;
    step();

    // four-address trace, cache always ready
    load_t1();
    b_rd = tot_rd;
    b_x = tot_xfer;
    run(-1, 100);
    chk("t1_access", access_count, 4);
    chk("t1_hit", hit_count, 1);
    chk("t1_miss", miss_count, 3);
    chk("t1_rd_pulses", tot_rd - b_rd, 4);
    chk("t1_xfers", tot_xfer - b_x, 4);
    // start_cyc is the first busy cycle, one after the sampling edge
    chk("t1_done_latency", done_cyc - start_cyc + 1, 13);
    chk("t1_addr2", xfer_addr[(b_x + 2) & 63], 15'h4010);
    chk("t1_addr3", xfer_addr[(b_x + 3) & 63], 15'h0010);
    chk("t1_period", xfer_cyc[(b_x + 1) & 63] - xfer_cyc[b_x & 63], 3);
    chk("t1_error", error, 0);
    step();
    step();
    chk("t1_hold_access", access_count, 4);

    // single-address trace
    trace[0] = 15'h1234;
    trace_len = 1;
    hit_mask = '0;
    b_rd = tot_rd;
    b_x = tot_xfer;
    run(-1, 100);
    chk("t2_rd_pulses", tot_rd - b_rd, 1);
    chk("t2_xfers", tot_xfer - b_x, 1);
    chk("t2_addr", xfer_addr[b_x & 63], 15'h1234);
    chk("t2_access", access_count, 1);
    chk("t2_hit", hit_count, 0);
    chk("t2_miss", miss_count, 1);

    // slow cache: ready after 5 low cycles
    trace[0] = 15'h0abc;
    trace[1] = 15'h7fff;
    trace_len = 2;
    hit_mask = 8'b0000_0001;
    delay = 5;
    b_x = tot_xfer;
    b_u = unstable;
    run(-1, 100);
    chk("t3_period", xfer_cyc[(b_x + 1) & 63] - xfer_cyc[b_x & 63], 8);
    chk("t3_stable", unstable - b_u, 0);
    chk("t3_addr1", xfer_addr[(b_x + 1) & 63], 15'h7fff);
    chk("t3_access", access_count, 2);
    chk("t3_hit", hit_count, 1);
    chk("t3_miss", miss_count, 1);

    // reset while waiting in REQ
    trace[0] = 15'h2222;
    trace[1] = 15'h3333;
    trace[2] = 15'h4444;
    trace_len = 3;
    hit_mask = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t4_in_req", cache_req, 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_req", cache_req, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_addr", cache_addr, 0);
    chk("t4_rst_access", access_count, 0);
    d0 = tot_done;
    r0 = tot_rd;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t4_no_done", tot_done - d0, 0);
    chk("t4_no_rd_en", tot_rd - r0, 0);

    // clean run after abort
    load_t1();
    delay = 0;
    run(-1, 100);
    chk("t5_access", access_count, 4);
    chk("t5_hit", hit_count, 1);
    chk("t5_miss", miss_count, 3);

    // extra start pulse mid-run is ignored
    b_rd = tot_rd;
    run(4, 100);
    chk("t6_access", access_count, 4);
    chk("t6_hit", hit_count, 1);
    chk("t6_miss", miss_count, 3);
    chk("t6_rd_pulses", tot_rd - b_rd, 4);

`ifdef CTRL_TIMEOUT_EN
    // cache stuck: 63 REQ cycles then abandon
    stuck = 1'b1;
    run(-1, 200);
    chk("t7_error", error, 1);
    chk("t7_access", access_count, 0);
    chk("t7_done_latency", done_cyc - start_cyc + 1, 66);
    stuck = 1'b0;
    load_t1();
    run(-1, 100);
    chk("t7_error_cleared", error, 0);
    chk("t7_access_after", access_count, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_trace_sequencer.md
# cache_trace_sequencer

Sequences the address-trace reader and the direct-mapped data cache: fetches one 15-bit address per transaction from the reader, presents it to the cache over a req/ready handshake, and tallies accesses, hits and misses until the trace is exhausted. Sits between the trace reader (`En` / `captured_data` / `dataFinish`) and the cache's access port in the top-level simulation harness.

## Interface
- `ADDR_W`, 15, trace/cache address width
- `CNT_W`, 16, width of each statistics counter
- `TIMEOUT`, 63, max cycles in REQ without `cache_ready` (only with CTRL_TIMEOUT_EN)

- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin a run; sampled only in IDLE
- `rd_en` out 1: reader enable (drives reader `En`)
- `rd_data` in ADDR_W: reader `captured_data`
- `rd_finish` in 1: reader `dataFinish`
- `cache_req` out 1: access request to cache
- `cache_addr` out ADDR_W: access address, stable while `cache_req`=1
- `cache_ready` in 1: cache accepts/completes the access this cycle
- `cache_hit` in 1: hit flag, valid only when `cache_req && cache_ready`
- `busy` out 1: high in any state except IDLE
- `done` out 1: one-cycle pulse at end of run
- `access_count`, `hit_count`, `miss_count` out CNT_W each: run statistics
- `error` out 1: sticky timeout flag

## Operation
- States: IDLE, FETCH, CAPTURE, REQ, DONE.
- IDLE: `start`=1 -> clear all three counters and `error`, go FETCH. Otherwise hold; counters keep last run's values.
- FETCH: `rd_en`=1 for exactly this cycle; -> CAPTURE.
- CAPTURE: `addr_q` <= `rd_data`, `last_q` <= `rd_finish`; -> REQ. `rd_en`=0.
- REQ: `cache_req`=1, `cache_addr`=`addr_q`. Transfer completes on a cycle with `cache_ready`=1: `access_count`+1, and `hit_count`+1 if `cache_hit` else `miss_count`+1. Then -> DONE if `last_q`, else -> FETCH. No transfer -> stay in REQ.
- The address captured alongside `rd_finish`=1 is valid and is issued before finishing.
- DONE: `done`=1 for one cycle; -> IDLE.
- Counters saturate at 2^CNT_W−1 (no wrap); `access_count` = `hit_count` + `miss_count` whenever none saturated.
- `start` outside IDLE is ignored.
- `rd_en` is never asserted outside FETCH; the reader is advanced exactly once per issued access.

## Timing
- Reset (async, immediate): state=IDLE; `rd_en`, `cache_req`, `busy`, `done`, `error` = 0; `cache_addr`, `addr_q`, `last_q`, all counters = 0.
- Reset mid-run aborts without `done`; outputs drop asynchronously, no further `rd_en`.
- `start` sampled at edge N -> `rd_en`=1 during cycle N+1, CAPTURE N+2, `cache_req`=1 from N+3.
- Minimum per-access period 3 cycles (FETCH, CAPTURE, REQ with `cache_ready` already high).
- `done` asserted the cycle after the final transfer; `busy` low from the cycle after `done`.
- `cache_addr` and `cache_req` are registered-state outputs, glitch-free, unchanged until transfer.

## Configuration
- `CTRL_TIMEOUT_EN` defined: a wait counter clears on entering REQ and increments each REQ cycle without `cache_ready`; on reaching `TIMEOUT` the access is abandoned (no counter update), `error` set sticky, -> DONE (`done` pulses). `error` clears only on reset or next accepted `start`.
- Not defined: REQ waits indefinitely; `error` tied to 0; `TIMEOUT` unused.

## Test plan
- Trace of 4 addresses (0x0010, 0x0010, 0x4010, 0x0010), cache `cache_ready` always 1, hits on 2nd access only -> `access_count`=4, `hit_count`=1, `miss_count`=3, `done` pulse 13 cycles after `start` sampled, 4 `rd_en` pulses.
- Single-address trace (`rd_finish`=1 on first capture) -> exactly one `cache_req` transfer with that address, then `done`; no second `rd_en`.
- `cache_ready` held low 5 cycles per access -> `cache_addr` stable throughout each REQ, counts unchanged until ready, per-access period 8 cycles.
- `rst` asserted while in REQ -> `cache_req`, `busy`, counters 0 immediately; no `done`; `start` afterwards runs a clean trace.
- `start` pulsed during a run -> ignored; counts match a run without the extra pulse.
- With `CTRL_TIMEOUT_EN`, TIMEOUT=63, `cache_ready` stuck 0 -> after 63 REQ cycles `error`=1, `done` pulses, `access_count`=0; next `start` clears `error`.
